// File: rtl/rename_ckpt.sv
// rtl/rename_ckpt.sv - register rename with bitmap free list, ready scoreboard and branch checkpoints
module rename_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int NUM_CKPT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic                          d_valid_i,
  input  logic                          d_is_branch_i,
  input  logic                          d_rs1_valid_i,
  input  logic                          d_rs2_valid_i,
  input  logic                          d_rd_valid_i,
  input  logic [$clog2(ARCH_REGS)-1:0]  d_rs1_i,
  input  logic [$clog2(ARCH_REGS)-1:0]  d_rs2_i,
  input  logic [$clog2(ARCH_REGS)-1:0]  d_rd_i,
  output logic                          r_valid_o,
  output logic [$clog2(PHYS_REGS)-1:0]  r_rs1_o,
  output logic [$clog2(PHYS_REGS)-1:0]  r_rs2_o,
  output logic                          r_rs1_ready_o,
  output logic                          r_rs2_ready_o,
  output logic [$clog2(PHYS_REGS)-1:0]  r_rd_o,
  output logic [$clog2(PHYS_REGS)-1:0]  r_rd_old_o,
  output logic [$clog2(NUM_CKPT)-1:0]   r_ckpt_tag_o,
  output logic                          rn_full_o,
  input  logic                          wb_valid_i,
  input  logic [$clog2(PHYS_REGS)-1:0]  wb_idx_i,
  input  logic                          commit_valid_i,
  input  logic [$clog2(PHYS_REGS)-1:0]  commit_free_i,
  input  logic                          br_valid_i,
  input  logic                          br_hit_i,
  input  logic [$clog2(NUM_CKPT)-1:0]   br_tag_i
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int CW = $clog2(NUM_CKPT);

  logic [PW-1:0]        map_q  [ARCH_REGS];
  logic [PW-1:0]        ckpt_q [NUM_CKPT][ARCH_REGS];
  logic [PHYS_REGS-1:0] mask_q [NUM_CKPT];
  logic [PHYS_REGS-1:0] used_q, ready_q, used_next, ready_next, alloc_bit;
  logic [CW-1:0]        head_q, tail_q;
  logic [CW:0]          count_q;
  logic [NUM_CKPT-1:0]  active;

  logic          mispredict, resolve, hit, restore;
  logic          alloc_req, found_free, accept, do_alloc, do_branch;
  logic [PW-1:0] free_idx, rs1_map, rs2_map;

  assign mispredict = br_valid_i & ~br_hit_i;
  assign resolve    = br_valid_i & (br_tag_i == head_q) & (count_q != '0);
  assign hit        = resolve & br_hit_i;
  assign restore    = resolve & ~br_hit_i;
  assign alloc_req  = d_rd_valid_i & (d_rd_i != '0);

  // Lowest free preg above 0; p0 is the hardwired x0 mapping and never handed out.
  always_comb begin
    free_idx   = '0;
    found_free = 1'b0;
    for (int p = PHYS_REGS - 1; p >= 1; p--) begin
      if (!used_q[p]) begin
        free_idx   = PW'(p);
        found_free = 1'b1;
      end
    end
  end

  assign rn_full_o = d_valid_i & ~mispredict &
                     ((d_is_branch_i & (count_q == (CW+1)'(NUM_CKPT))) | (alloc_req & ~found_free));
  assign accept    = d_valid_i & ~rn_full_o & ~mispredict;
  assign do_alloc  = accept & alloc_req;
  assign do_branch = accept & d_is_branch_i;
  assign alloc_bit = do_alloc ? ({{(PHYS_REGS-1){1'b0}}, 1'b1} << free_idx) : '0;

  assign rs1_map       = map_q[d_rs1_i];
  assign rs2_map       = map_q[d_rs2_i];
  assign r_valid_o     = accept;
  assign r_rs1_o       = (d_valid_i & d_rs1_valid_i) ? rs1_map : '0;
  assign r_rs2_o       = (d_valid_i & d_rs2_valid_i) ? rs2_map : '0;
  assign r_rs1_ready_o = d_valid_i & d_rs1_valid_i &
                         (ready_q[rs1_map] | (wb_valid_i & (wb_idx_i == rs1_map)));
  assign r_rs2_ready_o = d_valid_i & d_rs2_valid_i &
                         (ready_q[rs2_map] | (wb_valid_i & (wb_idx_i == rs2_map)));
  assign r_rd_o        = (d_valid_i & alloc_req) ? free_idx : '0;
  assign r_rd_old_o    = (d_valid_i & alloc_req) ? map_q[d_rd_i] : '0;
  assign r_ckpt_tag_o  = (d_valid_i & d_is_branch_i) ? tail_q : '0;

  always_comb begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      active[k] = {1'b0, CW'(k) - head_q} < count_q;
    end
  end

  // Later assignments win: allocation overrides a same-cycle commit or writeback.
  always_comb begin
    used_next  = used_q;
    ready_next = ready_q;
    if (restore) used_next = used_next & ~mask_q[head_q];
    if (commit_valid_i && commit_free_i != '0) used_next[commit_free_i] = 1'b0;
    if (wb_valid_i) ready_next[wb_idx_i] = 1'b1;
    used_next  = used_next | alloc_bit;
    ready_next = ready_next & ~alloc_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int k = 0; k < NUM_CKPT; k++) mask_q[k] <= '0;
      used_q  <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
      ready_q <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      used_q  <= used_next;
      ready_q <= ready_next;
      if (restore) begin
        for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= ckpt_q[head_q][i];
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_alloc) map_q[d_rd_i] <= free_idx;
        if (do_branch) begin
          for (int i = 0; i < ARCH_REGS; i++) ckpt_q[tail_q][i] <= map_q[i];
          tail_q <= tail_q + 1'b1;
        end
        // The branch's own rd is younger than its snapshot, so it lands in the new mask.
        for (int k = 0; k < NUM_CKPT; k++) begin
          if (do_branch && CW'(k) == tail_q) mask_q[k] <= alloc_bit;
          else if (active[k])               mask_q[k] <= mask_q[k] | alloc_bit;
        end
        head_q  <= head_q + CW'(hit);
        count_q <= count_q + (CW+1)'(do_branch) - (CW+1)'(hit);
      end
    end
  end

  tag_in_order: assert property (@(posedge clk) disable iff (!rst_ni)
    br_valid_i |-> br_tag_i == head_q);

endmodule
